lookup_regroup_table_pipe: RTL and testbench

- Parametrised, pipelined successor of the last-node regroup lookup.
- On each packet head popped from the input FIFO, it searches the regroup mapping RAM sequentially for the packet's flow ID. It returns the DMAC/outport result with a match flag, then holds until the packet tail.
- Unlike the fixed-depth version, it issues one RAM read per cycle across a software-configured entry count, tolerates configurable RAM latency, and keeps hit/miss statistics.

---
 rtl/lookup_regroup_table_pipe.sv | 171 +++++++++++++++++
 tb/tb_lookup_regroup_table_pipe.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lookup_regroup_table_pipe.sv
// Pipelined regroup lookup: each packet head starts a one-read-per-cycle search of the
// regroup mapping RAM for its flow ID. The result is strobed once, and the block then waits for the tail.
module lookup_regroup_table_pipe #(
  parameter int PKT_W      = 134,
  parameter int FLOWID_MSB = 124,
  parameter int FLOWID_W   = 14,
  parameter int RESULT_W   = 57,
  parameter int ADDR_W     = 8,
  parameter int RAM_LAT    = 2,
  parameter int CNT_W      = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [PKT_W-1:0]             iv_pkt_data,
  input  logic                         i_fifo_empty,
  input  logic [ADDR_W:0]              iv_entry_num,
  input  logic [FLOWID_W+RESULT_W-1:0] iv_regroup_ram_rdata,
  output logic                         o_regroup_ram_rd,
  output logic [ADDR_W-1:0]            ov_regroup_ram_raddr,
  output logic [RESULT_W-1:0]          ov_dmac_outport,
  output logic                         o_lookup_table_match_flag,
  output logic                         o_dmac_outport_wr,
  input  logic                         i_cnt_clr,
  output logic [CNT_W-1:0]             ov_hit_cnt,
  output logic [CNT_W-1:0]             ov_miss_cnt
);

  localparam int ENT_W = FLOWID_W + RESULT_W;
  localparam logic [ADDR_W:0]    MAX_N  = (ADDR_W+1)'(1) << ADDR_W;
  localparam logic [RAM_LAT-1:0] OLDEST = RAM_LAT'(1) << (RAM_LAT-1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_SEARCH   = 2'd1;
  localparam logic [1:0] S_DRAIN    = 2'd2;
  localparam logic [1:0] S_WAIT_EOP = 2'd3;

  logic [1:0]          state;
  logic [FLOWID_W-1:0] flowid;
  logic [ADDR_W:0]     n_ent;
  logic                tail_seen;
  logic [RAM_LAT-1:0]  pipe_vld;
  logic [ADDR_W-1:0]   pipe_addr [RAM_LAT];

  logic                is_head;
  logic                is_tail;
  logic [ADDR_W:0]     n_sel;
  logic [ADDR_W:0]     n_last;
  logic                ret_vld;
  logic                ret_zero;
  logic                ret_hit;
  logic                ret_last;
  logic                term;
  logic                pending;
  logic                issue_last;
  logic                unused_pkt_bits;

  assign is_head = !i_fifo_empty && (iv_pkt_data[PKT_W-1 -: 2] == 2'b01);
  assign is_tail = !i_fifo_empty && (iv_pkt_data[PKT_W-1 -: 2] == 2'b10);
  assign n_sel   = (iv_entry_num > MAX_N) ? MAX_N : iv_entry_num;
  assign n_last  = n_ent - (ADDR_W+1)'(1);
  assign unused_pkt_bits = ^iv_pkt_data;

  // The oldest pipeline stage is aligned with the RAM data for the address it carries.
  assign ret_vld  = pipe_vld[RAM_LAT-1];
  assign ret_zero = (iv_regroup_ram_rdata == '0);
  assign ret_hit  = !ret_zero && (iv_regroup_ram_rdata[ENT_W-1:RESULT_W] == flowid);
  assign ret_last = ({1'b0, pipe_addr[RAM_LAT-1]} == n_last);
  assign term     = (state == S_SEARCH) && ret_vld && (ret_hit || ret_zero || ret_last);

  // Reads still outstanding once this cycle's return has been consumed.
  assign pending    = ((pipe_vld & ~OLDEST) != '0) || o_regroup_ram_rd;
  assign issue_last = ({1'b0, ov_regroup_ram_raddr} == n_last);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld <= (pipe_vld << 1) | RAM_LAT'(o_regroup_ram_rd);
    end
  end

  // NOTE: the address pipeline is never read without its valid bit, so it carries no reset.
  always_ff @(posedge i_clk) begin
    for (int i = RAM_LAT-1; i > 0; i--) begin
      pipe_addr[i] <= pipe_addr[i-1];
    end
    pipe_addr[0] <= ov_regroup_ram_raddr;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state                     <= S_IDLE;
      flowid                    <= '0;
      n_ent                     <= '0;
      tail_seen                 <= 1'b0;
      o_regroup_ram_rd          <= 1'b0;
      ov_regroup_ram_raddr      <= '0;
      o_dmac_outport_wr         <= 1'b0;
      o_lookup_table_match_flag <= 1'b0;
      ov_dmac_outport           <= '0;
    end else begin
      // NOTE: result outputs default to zero each cycle, so they are only non-zero with the strobe.
      o_dmac_outport_wr         <= 1'b0;
      o_lookup_table_match_flag <= 1'b0;
      ov_dmac_outport           <= '0;
      case (state)
        S_IDLE: begin
          tail_seen <= 1'b0;
          if (is_head) begin
            flowid <= iv_pkt_data[FLOWID_MSB -: FLOWID_W];
            n_ent  <= n_sel;
            if (n_sel == '0) begin
              o_dmac_outport_wr <= 1'b1;
              state             <= S_WAIT_EOP;
            end else begin
              o_regroup_ram_rd     <= 1'b1;
              ov_regroup_ram_raddr <= '0;
              state                <= S_SEARCH;
            end
          end
        end
        S_SEARCH: begin
          if (is_tail) tail_seen <= 1'b1;
          if (term) begin
            o_dmac_outport_wr         <= 1'b1;
            o_lookup_table_match_flag <= ret_hit;
            ov_dmac_outport           <= ret_hit ? iv_regroup_ram_rdata[RESULT_W-1:0] : '0;
            o_regroup_ram_rd          <= 1'b0;
            ov_regroup_ram_raddr      <= '0;
            state                     <= pending ? S_DRAIN : S_WAIT_EOP;
          end else if (o_regroup_ram_rd) begin
            if (issue_last) begin
              o_regroup_ram_rd     <= 1'b0;
              ov_regroup_ram_raddr <= '0;
            end else begin
              ov_regroup_ram_raddr <= ov_regroup_ram_raddr + ADDR_W'(1);
            end
          end
        end
        S_DRAIN: begin
          if (is_tail) tail_seen <= 1'b1;
          if (!pending) state <= S_WAIT_EOP;
        end
        S_WAIT_EOP: begin
          if (tail_seen || is_tail) begin
            tail_seen <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Counters follow the registered strobe; a clear wins over a same-cycle increment.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ov_hit_cnt  <= '0;
      ov_miss_cnt <= '0;
    end else if (i_cnt_clr) begin
      ov_hit_cnt  <= '0;
      ov_miss_cnt <= '0;
    end else if (o_dmac_outport_wr) begin
      if (o_lookup_table_match_flag && (ov_hit_cnt != '1))
        ov_hit_cnt <= ov_hit_cnt + CNT_W'(1);
      if (!o_lookup_table_match_flag && (ov_miss_cnt != '1))
        ov_miss_cnt <= ov_miss_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_lookup_regroup_table_pipe.sv
// Scoreboard bench for lookup_regroup_table_pipe: two instances (RAM latency 2 and 3) share
// one stimulus stream and one RAM table; a negedge monitor checks each strobe against queued expectations.
module tb_lookup_regroup_table_pipe;

  localparam int PKT_W = 134;
  localparam int FW    = 14;
  localparam int RW    = 57;
  localparam int AW    = 8;
  localparam int EW    = FW + RW;
  localparam int CW    = 4;

  typedef struct {
    logic          hit;
    logic [RW-1:0] res;
    int            cyc;
    int            reads;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [PKT_W-1:0] pkt = '0;
  logic             empty = 1'b1;
  logic [AW:0]      num = '0;
  logic             clr = 1'b0;
  logic [EW-1:0]    mem [256];

  logic [EW-1:0] rdata2, rdata3;
  logic [EW-1:0] d2 [2];
  logic [EW-1:0] d3 [3];
  logic          rd2, rd3, wr2, wr3, flag2, flag3;
  logic [AW-1:0] addr2, addr3;
  logic [RW-1:0] res2, res3;
  logic [CW-1:0] hit2, hit3, miss2, miss3;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   cur_n = 0;
  int   rd_cnt [2];
  exp_t q2[$];
  exp_t q3[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lookup_regroup_table_pipe #(.RAM_LAT(2), .CNT_W(CW)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .iv_pkt_data(pkt), .i_fifo_empty(empty),
    .iv_entry_num(num), .iv_regroup_ram_rdata(rdata2), .o_regroup_ram_rd(rd2),
    .ov_regroup_ram_raddr(addr2), .ov_dmac_outport(res2), .o_lookup_table_match_flag(flag2),
    .o_dmac_outport_wr(wr2), .i_cnt_clr(clr), .ov_hit_cnt(hit2), .ov_miss_cnt(miss2));

  lookup_regroup_table_pipe #(.RAM_LAT(3), .CNT_W(CW)) u_dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .iv_pkt_data(pkt), .i_fifo_empty(empty),
    .iv_entry_num(num), .iv_regroup_ram_rdata(rdata3), .o_regroup_ram_rd(rd3),
    .ov_regroup_ram_raddr(addr3), .ov_dmac_outport(res3), .o_lookup_table_match_flag(flag3),
    .o_dmac_outport_wr(wr3), .i_cnt_clr(clr), .ov_hit_cnt(hit3), .ov_miss_cnt(miss3));

  // RAM models: data for an address registered in cycle t is presented in cycle t+latency.
  always @(posedge clk) begin
    d2[0] <= mem[addr2];
    d2[1] <= d2[0];
    d3[0] <= mem[addr3];
    d3[1] <= d3[0];
    d3[2] <= d3[1];
  end
  assign rdata2 = d2[1];
  assign rdata3 = d3[2];

  function automatic logic [RW-1:0] rval(input int i);
    return RW'(64'h00C0_FFEE_0000_0000) | RW'(i + 1);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon(input int idx, input logic wr, input logic flag, input logic [RW-1:0] res,
                     input logic rd, input logic [AW-1:0] addr);
    exp_t e;
    if (!rst_n) begin
      rd_cnt[idx] = 0;
      return;
    end
    if (wr) begin
      if ((idx == 0 && q2.size() == 0) || (idx == 1 && q3.size() == 0)) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_strobe: got strobe lat%0d, expected none (cycle %0d)", idx + 2, cyc);
      end else begin
        if (idx == 0) e = q2.pop_front();
        else          e = q3.pop_front();
        check("strobe_flag", 64'(flag), 64'(e.hit));
        check("strobe_result", 64'(res), 64'(e.res));
        check("strobe_cycle", 64'(cyc), 64'(e.cyc));
        check("read_count", 64'(rd_cnt[idx]), 64'(e.reads));
      end
      rd_cnt[idx] = 0;
    end else begin
      check("quiet_outputs", 64'({flag, res}), 64'(0));
    end
    if (rd) begin
      check("addr_in_range", 64'(int'(addr) < cur_n), 64'(1));
      rd_cnt[idx]++;
    end
  endtask

  always @(negedge clk) begin
    mon(0, wr2, flag2, res2, rd2, addr2);
    mon(1, wr3, flag3, res3, rd3, addr3);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] tag, input logic [FW-1:0] fid);
    pkt = '0;
    pkt[PKT_W-1 -: 2] = tag;
    pkt[124 -: FW] = fid;
    empty = 1'b0;
  endtask

  // Present a head and queue the expected strobe for both latencies; k = terminating address, -1 for N=0.
  task automatic head(input logic [FW-1:0] fid, input int n_cfg, input logic hit, input int k);
    exp_t e;
    int n_eff;
    step();
    send(2'b01, fid);
    num = (AW+1)'(n_cfg);
    n_eff = (n_cfg > 256) ? 256 : n_cfg;
    cur_n = n_eff;
    for (int lat = 2; lat <= 3; lat++) begin
      e.hit = hit;
      e.res = hit ? rval(k) : '0;
      if (k < 0) begin
        e.cyc   = cyc + 1;
        e.reads = 0;
      end else begin
        e.cyc   = cyc + 2 + k + lat;
        e.reads = (k + 1 + lat < n_eff) ? k + 1 + lat : n_eff;
      end
      if (lat == 2) q2.push_back(e);
      else          q3.push_back(e);
    end
    step();
    empty = 1'b1;
  endtask

  task automatic tail();
    step();
    send(2'b10, '0);
    step();
    empty = 1'b1;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 2000 && (q2.size() + q3.size()) != 0; i++) step();
    check("sb_drained", 64'(q2.size() + q3.size()), 64'(0));
  endtask

  task automatic packet(input logic [FW-1:0] fid, input int n_cfg, input logic hit, input int k,
                        input logic early_tail);
    head(fid, n_cfg, hit, k);
    if (early_tail) begin
      step();
      tail();
      wait_done();
    end else begin
      wait_done();
      tail();
    end
    repeat (6) step();
  endtask

  task automatic check_cnt(input string name, input int h, input int m);
    check({name, "_hit2"}, 64'(hit2), 64'(h));
    check({name, "_miss2"}, 64'(miss2), 64'(m));
    check({name, "_hit3"}, 64'(hit3), 64'(h));
    check({name, "_miss3"}, 64'(miss3), 64'(m));
  endtask

  task automatic check_zero(input string name);
    check({name, "_res2"}, 64'(res2), 64'(0));
    check({name, "_res3"}, 64'(res3), 64'(0));
    check({name, "_ctl2"}, 64'({wr2, flag2, rd2, addr2}), 64'(0));
    check({name, "_ctl3"}, 64'({wr3, flag3, rd3, addr3}), 64'(0));
    check_cnt(name, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {FW'(32'h2000 + i), rval(i)};
    mem[0]   = {FW'(14'h0005), rval(0)};
    mem[1]   = {FW'(14'h0007), rval(1)};
    mem[2]   = {FW'(14'h0009), rval(2)};
    mem[3]   = {FW'(14'h000A), rval(3)};
    mem[4]   = {FW'(14'h000B), rval(4)};
    mem[255] = {FW'(14'h003F), rval(255)};

    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    repeat (2) step();

    packet(14'h0005, 4, 1'b1, 0, 1'b0);   // hit at address 0
    packet(14'h000A, 4, 1'b1, 3, 1'b1);   // hit at last address, tail during search
    packet(14'h000B, 4, 1'b0, 3, 1'b0);   // match lies beyond N: miss
    mem[1] = '0;
    packet(14'h000A, 4, 1'b0, 1, 1'b0);   // invalid entry stops the search
    mem[1] = {FW'(14'h0007), rval(1)};

    // N=0 miss, tail three cycles later, then a head on the first idle cycle.
    head(14'h0005, 0, 1'b0, -1);
    step();
    step();
    send(2'b10, '0);
    head(14'h0005, 4, 1'b1, 0);
    wait_done();
    tail();
    repeat (6) step();

    packet(14'h003F, 511, 1'b1, 255, 1'b1); // clamped to full depth, hit at top address
    packet(14'h1234, 256, 1'b0, 255, 1'b0); // full-depth miss
    check_cnt("cnt_mid", 4, 4);

    for (int i = 0; i < 14; i++) begin
      head(14'h0001, 0, 1'b0, -1);
      tail();
    end
    repeat (4) step();
    wait_done();
    check_cnt("cnt_sat", 4, 15);

    // Clear held across both instances' hit strobes (T+4 and T+5).
    head(14'h0005, 4, 1'b1, 0);
    step();
    step();
    step();
    clr = 1'b1;
    step();
    step();
    clr = 1'b0;
    wait_done();
    tail();
    repeat (6) step();
    check_cnt("cnt_clr", 0, 0);

    // Reset during a long search: no strobe may follow.
    step();
    send(2'b01, 14'h1234);
    num = 9'd256;
    cur_n = 256;
    step();
    empty = 1'b1;
    repeat (20) step();
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("mid_reset");
    repeat (2) step();
    rst_n = 1'b1;
    repeat (300) step();
    check("no_pending", 64'(q2.size() + q3.size()), 64'(0));
    check_zero("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
